avalon_pio_input_debounced: RTL and testbench

- Avalon-MM slave input PIO: the input-direction counterpart of the team's output PIO.
- Samples WIDTH external inputs (push-buttons/switches) through a 2-flop synchronizer and per-bit debounce counters.
- Captures qualifying edges into a sticky register and raises a maskable level interrupt.
- Sits on the system interconnect next to the output PIOs; zero-wait-state, read latency 0.

---
 rtl/avalon_pio_input_debounced_if.sv | 12 +
 rtl/avalon_pio_input_debounced.sv | 104 ++++++++++
 tb/tb_avalon_pio_input_debounced.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_input_debounced_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO, plus its level interrupt.
interface avalon_pio_input_debounced_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/avalon_pio_input_debounced.sv
// Debounced input PIO: 2-flop sync, per-bit debounce counters, sticky edge capture
// and a maskable level interrupt behind a zero-wait-state Avalon-MM slave.
module avalon_pio_input_debounced_lane #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic stable,
    output logic update
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // update is the edge on which stable takes the new value
    assign update = (sync != stable) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (update) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module avalon_pio_input_debounced #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    avalon_pio_input_debounced_if.slave  bus,
    input  logic [WIDTH-1:0]             in_port
);
    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] stable, update;
    logic [WIDTH-1:0] cap_set, cap_clr;
    logic [WIDTH-1:0] irq_mask, edge_cap;
    logic             wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        avalon_pio_input_debounced_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .sync   (s2[i]),
            .stable (stable[i]),
            .update (update[i])
        );
    end

    // On an update edge s2 is the value stable is about to take, i.e. the new level
    assign cap_set = (EDGE_TYPE == 0) ? (update & s2)  :
                     (EDGE_TYPE == 1) ? (update & ~s2) : update;

    assign wr      = bus.chipselect && !bus.write_n;
    assign cap_clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr && bus.address == 2'd2)
                irq_mask <= bus.writedata[WIDTH-1:0];
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = stable;
            2'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
            2'd3:    bus.readdata[WIDTH-1:0] = edge_cap;
            default: bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(edge_cap & irq_mask);

    // Upper writedata bits are ignored when WIDTH < 32
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.writedata};
endmodule

// File: tb/tb_avalon_pio_input_debounced.sv
// Bench for the debounced input PIO: two instances (rising / falling capture) share
// stimulus and are checked against a window-based reference model.
module tb_avalon_pio_input_debounced;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int NH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [W-1:0] in_port;
    logic [1:0]  addr;
    logic        cs, wn;
    logic [31:0] wd;

    always #5 clk = ~clk;

    avalon_pio_input_debounced_if bus0 ();
    avalon_pio_input_debounced_if bus1 ();

    assign bus0.address = addr;
    assign bus0.chipselect = cs;
    assign bus0.write_n = wn;
    assign bus0.writedata = wd;
    assign bus1.address = addr;
    assign bus1.chipselect = cs;
    assign bus1.write_n = wn;
    assign bus1.writedata = wd;

    avalon_pio_input_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .in_port(in_port));
    avalon_pio_input_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .in_port(in_port));

    logic [31:0] rd [2];
    logic        iq [2];
    assign rd[0] = bus0.readdata;
    assign rd[1] = bus1.readdata;
    assign iq[0] = bus0.irq;
    assign iq[1] = bus1.irq;

    // Reference model: stable flips once the synchronized input has differed from it
    // for D consecutive samples, all taken after the previous flip (or reset).
    int           n;
    logic [W-1:0] hist [NH];
    logic [W-1:0] m_stab;
    int           m_u [W];
    logic [W-1:0] m_cap [2];
    logic [W-1:0] m_mask [2];

    int vectors;
    int miscompares;

    function automatic logic [31:0] exp_rd(int d, logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_stab};
            2'd2:    return {28'h0, m_mask[d]};
            2'd3:    return {28'h0, m_cap[d]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_irq(int d);
        return |(m_cap[d] & m_mask[d]);
    endfunction

    task automatic tick();
        logic [W-1:0] upd, nstab, clr;
        bit           all_diff;
        @(posedge clk);
        n++;
        if (n >= NH) begin
            $display("FAIL history_overflow: got cycle %0d, limit %0d", n, NH);
            $fatal(1, "history overflow");
        end
        if (reset) begin
            m_stab = '0;
            for (int i = 0; i < W; i++) m_u[i] = n;
            for (int d = 0; d < 2; d++) begin
                m_cap[d]  = '0;
                m_mask[d] = '0;
            end
            hist[n]   = '0;
            hist[n-1] = '0;
        end else begin
            upd = '0;
            for (int i = 0; i < W; i++) begin
                if (n >= m_u[i] + D) begin
                    all_diff = 1'b1;
                    for (int k = n - D - 1; k <= n - 2; k++)
                        if (hist[k][i] == m_stab[i]) all_diff = 1'b0;
                    upd[i] = all_diff;
                end
            end
            nstab = m_stab ^ upd;
            clr   = (cs && !wn && addr == 2'd3) ? wd[W-1:0] : '0;
            for (int d = 0; d < 2; d++)
                if (cs && !wn && addr == 2'd2) m_mask[d] = wd[W-1:0];
            m_cap[0] = (m_cap[0] & ~clr) | (upd & nstab);
            m_cap[1] = (m_cap[1] & ~clr) | (upd & ~nstab);
            m_stab = nstab;
            for (int i = 0; i < W; i++) if (upd[i]) m_u[i] = n;
            hist[n] = in_port;
        end
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
        cs = 1'b1; wn = 1'b0; addr = a; wd = data;
        tick();
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] alist [3];
        alist = '{2'd0, 2'd2, 2'd3};
        reset = 1'b1; in_port = '0; cs = 1'b0; wn = 1'b1; addr = 2'd0; wd = '0;
        repeat (3) tick();
        foreach (alist[j]) begin
            addr = alist[j];
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (rd[d] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL reset_readdata dut%0d addr%0d: got %h expected 0", d, addr, rd[d]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (iq[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_irq dut%0d: got %b expected 0", d, iq[d]);
            end
        end
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_latency();
        addr = 2'd0;
        in_port = 4'b0001;
        for (int j = 0; j <= 5; j++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (rd[d] !== ((j == 5) ? 32'h1 : 32'h0)) begin
                    miscompares++;
                    $display("FAIL latency_data dut%0d edge k+%0d: got %h expected %h",
                             d, j, rd[d], (j == 5) ? 32'h1 : 32'h0);
                end
            end
        end
        addr = 2'd3;
        #1;
        vectors++;
        if (rd[0] !== 32'h1) begin
            miscompares++;
            $display("FAIL latency_capture_rise: got %h expected 1", rd[0]);
        end
        vectors++;
        if (rd[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL latency_capture_fall_inst: got %h expected 0", rd[1]);
        end
        vectors++;
        if (iq[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_irq_masked: got %b expected 0", iq[0]);
        end
    endtask

    task automatic test_mask_clear();
        bus_write(2'd2, 32'h1);
        vectors++;
        if (iq[0] !== 1'b1 || iq[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_irq: got %b%b expected 10", iq[0], iq[1]);
        end
        vectors++;
        if (rd[0] !== 32'h1) begin
            miscompares++;
            $display("FAIL mask_readback: got %h expected 1", rd[0]);
        end
        bus_write(2'd3, 32'h1);
        vectors++;
        if (rd[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL w1c_capture: got %h expected 0", rd[0]);
        end
        vectors++;
        if (iq[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c_irq: got %b expected 0", iq[0]);
        end
    endtask

    task automatic test_glitch();
        addr = 2'd0;
        in_port = 4'b0011;
        repeat (3) tick();
        in_port = 4'b0001;
        for (int j = 0; j < 8; j++) begin
            tick();
            vectors++;
            if (rd[0] !== 32'h1 || rd[1] !== 32'h1) begin
                miscompares++;
                $display("FAIL glitch_data cycle %0d: got %h/%h expected 1", j, rd[0], rd[1]);
            end
        end
        addr = 2'd3;
        #1;
        vectors++;
        if (rd[0] !== 32'h0 || rd[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL glitch_capture: got %h/%h expected 0", rd[0], rd[1]);
        end
    endtask

    task automatic test_falling();
        in_port = 4'b0000;
        repeat (6) tick();
        addr = 2'd3;
        #1;
        vectors++;
        if (rd[1] !== 32'h1 || rd[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL falling_capture: got %h/%h expected 0/1", rd[0], rd[1]);
        end
        vectors++;
        if (iq[1] !== 1'b1 || iq[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL falling_irq: got %b/%b expected 0/1", iq[0], iq[1]);
        end
    endtask

    task automatic test_simultaneous();
        in_port = 4'b0001;
        repeat (5) tick();
        // the 6th edge both captures the rise and carries a W1C of bit 0
        bus_write(2'd3, 32'h1);
        addr = 2'd3;
        #1;
        vectors++;
        if (rd[0] !== 32'h1) begin
            miscompares++;
            $display("FAIL set_beats_clear: got %h expected 1", rd[0]);
        end
        vectors++;
        if (rd[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL rise_ignored_fall_inst: got %h expected 0", rd[1]);
        end
        vectors++;
        if (iq[0] !== 1'b1 || iq[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL simultaneous_irq: got %b/%b expected 1/0", iq[0], iq[1]);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int j = 0; j < 500; j++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) begin
                cs = 1'b1; wn = 1'b0;
                addr = 2'($urandom);
                wd = $urandom;
            end else begin
                cs = 1'($urandom); wn = 1'b1;
            end
            tick();
            cs = 1'b0; wn = 1'b1;
            addr = 2'($urandom);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (rd[d] !== exp_rd(d, addr)) begin
                    miscompares++;
                    $display("FAIL random_readdata dut%0d addr%0d cycle %0d: got %h expected %h",
                             d, addr, j, rd[d], exp_rd(d, addr));
                end
                vectors++;
                if (iq[d] !== exp_irq(d)) begin
                    miscompares++;
                    $display("FAIL random_irq dut%0d cycle %0d: got %b expected %b", d, j, iq[d], exp_irq(d));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] alist [3];
        alist = '{2'd0, 2'd2, 2'd3};
        in_port = 4'b0000;
        repeat (8) tick();
        in_port = 4'b1111;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        foreach (alist[j]) begin
            addr = alist[j];
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (rd[d] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL midreset_readdata dut%0d addr%0d: got %h expected 0", d, addr, rd[d]);
                end
            end
        end
        vectors++;
        if (iq[0] !== 1'b0 || iq[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_irq: got %b/%b expected 0/0", iq[0], iq[1]);
        end
        reset = 1'b0;
        addr = 2'd0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            vectors++;
            if (rd[0] !== ((j == 6) ? 32'hF : 32'h0)) begin
                miscompares++;
                $display("FAIL boot_held_data edge r+%0d: got %h expected %h", j, rd[0], (j == 6) ? 32'hF : 32'h0);
            end
        end
        addr = 2'd3;
        #1;
        vectors++;
        if (rd[0] !== 32'hF || rd[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL boot_held_capture: got %h/%h expected F/0", rd[0], rd[1]);
        end
        vectors++;
        if (rd[0] !== exp_rd(0, 2'd3)) begin
            miscompares++;
            $display("FAIL boot_held_model: got %h expected %h", rd[0], exp_rd(0, 2'd3));
        end
    endtask

    initial begin
        n = 0;
        vectors = 0;
        miscompares = 0;
        m_stab = '0;
        for (int i = 0; i < W; i++) m_u[i] = 0;
        for (int d = 0; d < 2; d++) begin
            m_cap[d]  = '0;
            m_mask[d] = '0;
        end
        for (int k = 0; k < NH; k++) hist[k] = '0;
        test_reset();
        test_latency();
        test_mask_clear();
        test_glitch();
        test_falling();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
